// File: rtl/fp_addsub_seq.sv
// Purpose: multi-cycle floating-point add/subtract with round-to-nearest-even; optional flags via FP_ADDSUB_FLAGS_EN.
// Latency: specials 2 cycles, cancellation 3, normal path 4 + max(k,1) where k = normalising left shifts (accept cycle = 1).
// Backpressure: one op in flight; in_ready only in IDLE, result/out_valid held in DONE until out_ready.
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result
`ifdef FP_ADDSUB_FLAGS_EN
   ,
   output logic         flag_inv,
   output logic         flag_ovf,
   output logic         flag_unf,
   output logic         flag_inx
`endif
);

   // mantissa datapath {hidden, frac, guard, round, sticky}; one extra carry bit in man_q
   localparam int MW = MAN_W + 4;
   // exponent carries two spare bits so over/underflow stays visible
   localparam int EW = EXP_W + 2;
   localparam logic [EW-1:0]    EMAX   = {2'b00, {EXP_W{1'b1}}};
   localparam logic [EW-1:0]    E_ONE  = EW'(1);
   localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W + 3);
   localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

   state_t        state;
   logic [W-1:0]  a_q, b_q;
   logic          sub_q;
   logic          sign_q, eff_sub_q;
   logic [EW-1:0] exp_q;
   logic [MW-1:0] ma_q, mb_q;
   logic [MW:0]   man_q;

   // operand fields; b's sign already folded with the operation
   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;

   assign sa     = a_q[W-1];
   assign sb     = b_q[W-1] ^ sub_q;
   assign ea     = a_q[W-2:MAN_W];
   assign eb     = b_q[W-2:MAN_W];
   assign fa     = a_q[MAN_W-1:0];
   assign fb     = b_q[MAN_W-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (&ea) && (fa == '0);
   assign b_inf  = (&eb) && (fb == '0);
   assign a_nan  = (&ea) && (fa != '0);
   assign b_nan  = (&eb) && (fb != '0);
   assign swap   = (b_q[W-2:0] > a_q[W-2:0]);

   logic             spec_hit, spec_inv;
   logic [W-1:0]     spec_res;
   logic             big_s;
   logic [EXP_W-1:0] big_e, small_e, shamt;
   logic [MAN_W-1:0] big_f, small_f;
   logic [MW-1:0]    m_small, mb_al;

   // resolve special operands and align the smaller magnitude with guard/round/sticky
   always_comb begin
      spec_hit = 1'b1;
      spec_inv = 1'b0;
      spec_res = '0;
      if (a_nan || b_nan) begin
         spec_res = QNAN;
      end else if (a_inf && b_inf) begin
         spec_inv = (sa != sb);
         spec_res = (sa != sb) ? QNAN : {sa, a_q[W-2:0]};
      end else if (a_inf) begin
         spec_res = {sa, a_q[W-2:0]};
      end else if (b_inf) begin
         spec_res = {sb, b_q[W-2:0]};
      end else if (a_zero && b_zero) begin
         spec_res = {sa & sb, {(W-1){1'b0}}};
      end else if (b_zero) begin
         spec_res = {sa, a_q[W-2:0]};
      end else if (a_zero) begin
         spec_res = {sb, b_q[W-2:0]};
      end else begin
         spec_hit = 1'b0;
      end

      big_s   = swap ? sb : sa;
      big_e   = swap ? eb : ea;
      small_e = swap ? ea : eb;
      big_f   = swap ? fb : fa;
      small_f = swap ? fa : fb;
      shamt   = big_e - small_e;
      m_small = {1'b1, small_f, 3'b000};
      if (shamt >= SH_MAX) begin
         mb_al = {{(MW-1){1'b0}}, 1'b1};
      end else begin
         mb_al    = m_small >> shamt;
         mb_al[0] = mb_al[0] | (|(m_small & ~({MW{1'b1}} << shamt)));
      end
   end

   logic [MW:0]    add_res, man_shl;
   logic [EW-1:0]  exp_dec, rnd_e;
   logic           rnd_up, rnd_inx;
   logic [MAN_W:0] rnd_f;

   // magnitude add/subtract, one-bit normalise step and RNE rounding
   always_comb begin
      add_res = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
      man_shl = {man_q[MW-1:0], 1'b0};
      exp_dec = exp_q - E_ONE;
      rnd_inx = man_q[2] | man_q[1] | man_q[0];
      rnd_up  = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
      rnd_f   = {1'b0, man_q[MW-2:3]} + {{MAN_W{1'b0}}, rnd_up};
      rnd_e   = exp_q + {{(EW-1){1'b0}}, rnd_f[MAN_W]};
   end

   // operation sequencer with registered handshake, result and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         exp_q     <= '0;
         ma_q      <= '0;
         mb_q      <= '0;
         man_q     <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
         flag_inv  <= 1'b0;
         flag_ovf  <= 1'b0;
         flag_unf  <= 1'b0;
         flag_inx  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  sub_q    <= sub;
                  in_ready <= 1'b0;
                  state    <= ALIGN;
`ifdef FP_ADDSUB_FLAGS_EN
                  flag_inv <= 1'b0;
                  flag_ovf <= 1'b0;
                  flag_unf <= 1'b0;
                  flag_inx <= 1'b0;
`endif
               end
            end
            ALIGN: begin
               if (spec_hit) begin
                  result    <= spec_res;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef FP_ADDSUB_FLAGS_EN
                  flag_inv  <= spec_inv;
`endif
               end else begin
                  sign_q    <= big_s;
                  eff_sub_q <= sa ^ sb;
                  exp_q     <= {2'b00, big_e};
                  ma_q      <= {1'b1, big_f, 3'b000};
                  mb_q      <= mb_al;
                  state     <= ADD;
               end
            end
            ADD: begin
               if (add_res == '0) begin
                  result    <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  man_q <= add_res;
                  state <= NORM;
               end
            end
            NORM: begin
               if (man_q[MW]) begin
                  man_q <= {1'b0, man_q[MW:2], man_q[1] | man_q[0]};
                  exp_q <= exp_q + E_ONE;
                  state <= ROUND;
               end else if (man_q[MW-1]) begin
                  state <= ROUND;
               end else if (exp_dec == '0) begin
                  result    <= {sign_q, {(W-1){1'b0}}};
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef FP_ADDSUB_FLAGS_EN
                  flag_unf  <= 1'b1;
                  flag_inx  <= 1'b1;
`endif
               end else begin
                  man_q <= man_shl;
                  exp_q <= exp_dec;
                  if (man_shl[MW-1]) state <= ROUND;
               end
            end
            ROUND: begin
               if (rnd_e >= EMAX) begin
                  result   <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_ADDSUB_FLAGS_EN
                  flag_ovf <= 1'b1;
                  flag_inx <= 1'b1;
`endif
               end else begin
                  result   <= {sign_q, rnd_e[EXP_W-1:0], rnd_f[MAN_W-1:0]};
`ifdef FP_ADDSUB_FLAGS_EN
                  flag_inx <= rnd_inx;
`endif
               end
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef FP_ADDSUB_FLAGS_EN
   // rounding inexactness only feeds the flag outputs
   logic unused_inx;
   assign unused_inx = rnd_inx;
`endif

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (EXP_W=8, MAN_W=23).
// Each scenario task drives its own vectors and compares against hand-computed values.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b, result;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
`ifdef FP_ADDSUB_FLAGS_EN
   logic        flag_inv, flag_ovf, flag_unf, flag_inx;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] r;
      logic [7:0]  lat;
      logic [3:0]  fl;   // {inv, ovf, unf, inx}
   } vec_t;

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
`ifdef FP_ADDSUB_FLAGS_EN
      ,
      .flag_inv  (flag_inv),
      .flag_ovf  (flag_ovf),
      .flag_unf  (flag_unf),
      .flag_inx  (flag_inx)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Issue one operation, measure latency (accept cycle counts as 1), then retire it.
   task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        output logic [31:0] res, output int lat, output logic [3:0] fl);
      a        = va;
      b        = vb;
      sub      = vs;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid) begin
         res = result;
`ifdef FP_ADDSUB_FLAGS_EN
         fl  = {flag_inv, flag_ovf, flag_unf, flag_inx};
`else
         fl  = 4'h0;
`endif
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end else begin
         res = 'x;
         fl  = 'x;
      end
   endtask

   task automatic run_table(input string name, input vec_t tv[], input int n);
      logic [31:0] r;
      logic [3:0]  fl;
      int          lat;
      for (int i = 0; i < n; i++) begin
         do_op(tv[i].a, tv[i].b, tv[i].s, r, lat, fl);
         checks++;
         if (r !== tv[i].r) begin
            failures++;
            $display("FAIL %s[%0d] result got=%h exp=%h", name, i, r, tv[i].r);
         end
         checks++;
         if (lat !== int'(tv[i].lat)) begin
            failures++;
            $display("FAIL %s[%0d] latency got=%0d exp=%0d", name, i, lat, tv[i].lat);
         end
`ifdef FP_ADDSUB_FLAGS_EN
         checks++;
         if (fl !== tv[i].fl) begin
            failures++;
            $display("FAIL %s[%0d] flags got=%b exp=%b", name, i, fl, tv[i].fl);
         end
`endif
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
         failures++;
         $display("FAIL reset_state got rdy=%b vld=%b res=%h exp rdy=1 vld=0 res=0",
                  in_ready, out_valid, result);
      end
`ifdef FP_ADDSUB_FLAGS_EN
      checks++;
      if ({flag_inv, flag_ovf, flag_unf, flag_inx} !== 4'h0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {flag_inv, flag_ovf, flag_unf, flag_inx});
      end
`endif
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_normal();
      vec_t tv[7];
      tv[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 8'd5,  4'b0000}; // 1+1
      tv[1] = '{32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 8'd5,  4'b0000}; // 1.5+2.5
      tv[2] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 8'd5,  4'b0000}; // 1-2
      tv[3] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 8'd28, 4'b0000}; // long normalise
      tv[4] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 8'd5,  4'b0001}; // tie to even, down
      tv[5] = '{32'h4B800001, 32'h3F800000, 1'b0, 32'h4B800002, 8'd5,  4'b0001}; // tie to even, up
      tv[6] = '{32'h4B7FFFFF, 32'h3F000000, 1'b0, 32'h4B800000, 8'd5,  4'b0001}; // rounding carries into exp
      run_table("normal", tv, 7);
   endtask

   task automatic test_specials();
      vec_t tv[10];
      tv[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 8'd5, 4'b0101}; // overflow
      tv[1] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 8'd2, 4'b1000}; // inf-inf
      tv[2] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 8'd2, 4'b0000}; // NaN in
      tv[3] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 8'd2, 4'b0000}; // -inf + 1
      tv[4] = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 8'd3, 4'b0000}; // exact cancel
      tv[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 8'd2, 4'b0000}; // -0 + -0
      tv[6] = '{32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 8'd2, 4'b0000}; // denormal flushed
      tv[7] = '{32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 8'd2, 4'b0000}; // x+0
      tv[8] = '{32'h00000000, 32'h40A00000, 1'b1, 32'hC0A00000, 8'd2, 4'b0000}; // 0-5
      tv[9] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 8'd4, 4'b0011}; // underflow
      run_table("special", tv, 10);
   endtask

   task automatic test_back_to_back();
      int n;
      a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_wait got vld=%b exp vld=1", out_valid);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || result !== 32'h40000000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold[%0d] got vld=%b res=%h rdy=%b exp vld=1 res=40000000 rdy=0",
                     i, out_valid, result, in_ready);
         end
      end
      // retire and offer the next op in the same cycle
      out_ready = 1'b1; in_valid = 1'b1;
      a = 32'h3F800000; b = 32'h40000000; sub = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_retire got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept got rdy=%b exp rdy=0", in_ready);
      end
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (result !== 32'h40400000 || n != 5) begin
         failures++;
         $display("FAIL b2b_result got res=%h lat=%0d exp res=40400000 lat=5", result, n);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [3:0]  fl;
      int          lat;
      a = 32'h3F800000; b = 32'h3F7FFFFF; sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid got vld=%b rdy=%b res=%h exp vld=0 rdy=1 res=0",
                  out_valid, in_ready, result);
      end
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(32'h3F800000, 32'h3F800000, 1'b0, r, lat, fl);
      checks++;
      if (r !== 32'h40000000 || lat != 5) begin
         failures++;
         $display("FAIL rst_next_op got res=%h lat=%0d exp res=40000000 lat=5", r, lat);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_specials();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
